fwd_hazard_ctrl: RTL
====================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Parametrised forwarding + hazard controller for the 5-stage MIPS pipeline.
//  Sits beside ID/EX. Selects bypass sources for both ALU operands from
//  FWD_STAGES later stages. Detects load-use hazards and tracks one
//  multi-cycle MUL/DIV unit with a small state machine, producing the IF/ID
//  stall. Also keeps a saturating stall-cycle counter.
// PARAMETERS
//  FWD_STAGES  2   number of bypass stages; index 0 = youngest (EX/MEM), 1 = MEM/WB, ...
//  MD_LAT      4   MUL/DIV latency in cycles from md_start to md_done (>=2)
//  CNT_W       16  stall counter width
//  SEL_W       derived: clog2(FWD_STAGES+1); not overridden
// PORTS
//  clk          in   1                clock, rising edge
//  rst          in   1                synchronous reset, active high
//  stg_regwrite in   FWD_STAGES       per-stage register-write enable
//  stg_rd       in   5*FWD_STAGES     per-stage destination; stage k at [5k+4:5k]
//  idex_rs      in   5                EX-stage source A
//  idex_rt      in   5                EX-stage source B
//  idex_memread in   1                EX-stage instruction is a load
//  idex_rd      in   5                EX-stage destination
//  ifid_rs      in   5                ID-stage source A
//  ifid_rt      in   5                ID-stage source B
//  ifid_uses_rt in   1                ID-stage instruction reads rt
//  ifid_is_md   in   1                ID-stage instruction is MUL/DIV
//  md_start     in   1                MUL/DIV issued from EX this cycle
//  md_rd        in   5                MUL/DIV destination register
//  flush        in   1                branch flush of IF/ID
//  fwd_a        out  SEL_W            0 = regfile, k+1 = stage k, operand A
//  fwd_b        out  SEL_W            same encoding, operand B
//  stall        out  1                hold PC and IF/ID, bubble into ID/EX
//  md_busy      out  1                MUL/DIV unit not idle
//  md_done      out  1                one-cycle pulse: MUL/DIV result valid
//  md_wb_rd     out  5                destination for md_done write-back
//  md_overrun   out  1                sticky: md_start seen while BUSY
//  stall_cnt    out  CNT_W            saturating count of stall cycles
// BEHAVIOUR
//  Forwarding (combinational):
//  - fwd_a = k+1 for the lowest k where stg_regwrite[k], stg_rd[k]!=0 and
//    stg_rd[k]==idex_rs. Otherwise 0. fwd_b is the same using idex_rt.
//  - Younger stage always wins. A and B are independent. Both are forced to 0 while rst.
//  Load-use: lu = idex_memread & idex_rd!=0 & (idex_rd==ifid_rs |
//    (ifid_uses_rt & idex_rd==ifid_rt)). A flush in the same cycle masks lu.
//  MUL/DIV FSM (registered). States IDLE, BUSY, DONE. Down-counter width clog2(MD_LAT).
//  - IDLE + md_start: latch md_rd, cnt<=MD_LAT-2, go to BUSY.
//  - BUSY: cnt decrements. At cnt==0, go to DONE.
//  - BUSY + md_start: request dropped, md_overrun<=1 (cleared only by rst).
//  - DONE: md_done=1 and md_wb_rd=latched rd for exactly 1 cycle.
//    With md_start: reload and go to BUSY (back-to-back). Otherwise go to IDLE.
//  - md_done rises exactly MD_LAT cycles after the md_start edge.
//  - md_busy = (state!=IDLE).
//  - flush never cancels an in-flight MUL/DIV (it is older than the branch).
//  Stall = lu | md_raw | md_struct.
//  - md_raw: state!=IDLE, latched rd!=0, and latched rd matches ifid_rs, or matches
//    ifid_rt when ifid_uses_rt. Held through DONE, released the next cycle.
//  - md_struct: ifid_is_md & state==BUSY.
//  stall_cnt: +1 on each cycle with stall=1; holds at all-ones (no wrap).
//  Reset (sync): state=IDLE, cnt=0, latched rd=0, md_done=0, md_wb_rd=0,
//    md_overrun=0, stall_cnt=0, stall=0. Mid-operation reset drops the pending
//    op with no md_done pulse.
// STRUCTURE
//  - Shared package hazard_pkg:
//    - MD state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2)
//    - REG_ZERO=5'd0
//    - clog2 function for SEL_W
//  - Sub-module md_scoreboard: FSM, counter, latched rd, overrun flag, md_raw/md_struct.
//  - Top: forwarding priority loop, load-use, stall OR, counter.
// TESTING
//  1 stg0 wr rd=8, stg1 wr rd=8, idex_rs=8 -> fwd_a=1 (younger wins); stg0 rd=0 -> fwd_a=2.
//  2 idex_memread, idex_rd=9, ifid_rt=9, ifid_uses_rt=0 -> stall=0; uses_rt=1 -> stall=1.
//  3 md_start rd=12 (MD_LAT=4) at t0 -> md_busy t1..t4, md_done only at t4, ifid_rs=12 stalls t1..t4.
//  4 md_start again in DONE cycle -> second md_done 4 cycles later, no IDLE gap, md_overrun=0.
//  5 md_start while BUSY -> md_overrun=1 stays set, single md_done. rst mid-BUSY -> IDLE, no md_done.
//  6 force stall=1 for 2^CNT_W+5 cycles -> stall_cnt saturates at all-ones. rst -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding / hazard controller.
// MUL/DIV state encoding, the zero-register constant and a ceil-log2 helper.
package hazard_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/md_scoreboard.sv
// Tracks the single multi-cycle MUL/DIV unit: IDLE -> BUSY -> DONE, md_done exactly MD_LAT
// cycles after md_start; a start while BUSY is dropped and sets the sticky overrun flag.
module md_scoreboard
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       md_start,
  input  logic [4:0] md_rd,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       ifid_uses_rt,
  input  logic       ifid_is_md,
  output logic       md_busy,
  output logic       md_done,
  output logic [4:0] md_wb_rd,
  output logic       md_overrun,
  output logic       md_raw,
  output logic       md_struct
);

  localparam int CW = (clog2(MD_LAT) < 1) ? 1 : clog2(MD_LAT);
  // BUSY spans MD_LAT-1 cycles, DONE is the MD_LAT-th
  localparam logic [CW-1:0] RELOAD = CW'(MD_LAT - 2);

  md_state_e      state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [4:0]     rd_q, rd_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MD_IDLE;
      cnt        <= '0;
      rd_q       <= REG_ZERO;
      md_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rd_q  <= rd_nxt;
      if (state == MD_BUSY && md_start) md_overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = rd_q;
    case (state)
      MD_IDLE: begin
        if (md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = RELOAD;
          rd_nxt    = md_rd;
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_nxt = MD_DONE;
        else           cnt_nxt   = cnt - CW'(1);
      end
      MD_DONE: begin
        if (md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = RELOAD;
          rd_nxt    = md_rd;
        end else begin
          state_nxt = MD_IDLE;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  assign md_busy   = (state != MD_IDLE);
  assign md_done   = !rst && (state == MD_DONE);
  assign md_wb_rd  = md_done ? rd_q : REG_ZERO;
  // The pending result blocks readers until the write-back cycle has passed.
  assign md_raw    = (state != MD_IDLE) && (rd_q != REG_ZERO) &&
                     ((rd_q == ifid_rs) || (ifid_uses_rt && rd_q == ifid_rt));
  assign md_struct = ifid_is_md && (state == MD_BUSY);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and stall generation beside ID/EX; forwarding is combinational,
// the MUL/DIV tracker and stall counter are registered; stall holds PC and IF/ID.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int FWD_STAGES = 2,
  parameter  int MD_LAT     = 4,
  parameter  int CNT_W      = 16,
  localparam int SEL_W      = clog2(FWD_STAGES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [FWD_STAGES-1:0]   stg_regwrite,
  input  logic [5*FWD_STAGES-1:0] stg_rd,
  input  logic [4:0]              idex_rs,
  input  logic [4:0]              idex_rt,
  input  logic                    idex_memread,
  input  logic [4:0]              idex_rd,
  input  logic [4:0]              ifid_rs,
  input  logic [4:0]              ifid_rt,
  input  logic                    ifid_uses_rt,
  input  logic                    ifid_is_md,
  input  logic                    md_start,
  input  logic [4:0]              md_rd,
  input  logic                    flush,
  output logic [SEL_W-1:0]        fwd_a,
  output logic [SEL_W-1:0]        fwd_b,
  output logic                    stall,
  output logic                    md_busy,
  output logic                    md_done,
  output logic [4:0]              md_wb_rd,
  output logic                    md_overrun,
  output logic [CNT_W-1:0]        stall_cnt
);

  logic lu, md_raw, md_struct;

  // Scan oldest to youngest so the youngest matching stage overwrites.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    if (!rst) begin
      for (int k = FWD_STAGES - 1; k >= 0; k--) begin
        if (stg_regwrite[k] && stg_rd[5*k +: 5] != REG_ZERO) begin
          if (stg_rd[5*k +: 5] == idex_rs) fwd_a = SEL_W'(k + 1);
          if (stg_rd[5*k +: 5] == idex_rt) fwd_b = SEL_W'(k + 1);
        end
      end
    end
  end

  assign lu = idex_memread && (idex_rd != REG_ZERO) && !flush &&
              ((idex_rd == ifid_rs) || (ifid_uses_rt && idex_rd == ifid_rt));

  md_scoreboard #(.MD_LAT(MD_LAT)) u_md (
    .clk          (clk),
    .rst          (rst),
    .md_start     (md_start),
    .md_rd        (md_rd),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .ifid_is_md   (ifid_is_md),
    .md_busy      (md_busy),
    .md_done      (md_done),
    .md_wb_rd     (md_wb_rd),
    .md_overrun   (md_overrun),
    .md_raw       (md_raw),
    .md_struct    (md_struct)
  );

  assign stall = !rst && (lu || md_raw || md_struct);

  always_ff @(posedge clk) begin
    if (rst)                             stall_cnt <= '0;
    else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule
